fpu_fma_wb_queue: RTL and testbench

- Downstream neighbour of the FMA pipe. It tracks each op issued into the fixed-latency FMA pipe with its destination tag.
- It captures the pipe's result and exception flags on the cycle they emerge, and buffers them in a small FIFO for the shared FP register-file write port.
- Load writeback takes that port with priority over this block. A credit counter therefore back-pressures issue so that no FMA result is ever dropped.

---
 rtl/fpu_fma_wb_queue_pkg.sv | 23 ++
 rtl/fpu_wb_fifo.sv | 50 +++++
 rtl/fpu_fma_wb_queue.sv | 99 +++++++++
 tb/tb_fpu_fma_wb_queue.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_fma_wb_queue_pkg.sv
// Shared FPU writeback types: field widths, exception-flag bit positions and
// the payload carried from the FMA pipe to the register-file write port.
package fpu_fma_wb_queue_pkg;

   localparam int unsigned FP_TAG_W   = 5;
   localparam int unsigned FP_EXC_W   = 5;
   localparam int unsigned FP_REC_W_D = 65;

   // Bit positions within the exception-flag vector
   localparam int unsigned EXC_NV = 4;
   localparam int unsigned EXC_DZ = 3;
   localparam int unsigned EXC_OF = 2;
   localparam int unsigned EXC_UF = 1;
   localparam int unsigned EXC_NX = 0;

   typedef struct packed {
      logic [FP_TAG_W-1:0]   rd;
      logic                  single;
      logic [FP_REC_W_D-1:0] data;
      logic [FP_EXC_W-1:0]   exc;
   } fpu_wb_entry_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// Small result FIFO for FMA writeback entries; head is read combinationally
// from storage, pointers and count are registered.
module fpu_wb_fifo
   import fpu_fma_wb_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  fpu_wb_entry_t                push_entry,
   input  logic                         pop,
   output fpu_wb_entry_t                head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fpu_wb_entry_t    mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             do_pop;

   assign do_pop = pop && (count != '0);
   assign head   = mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem   <= '{default: '0};
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= push_entry;
            wptr      <= wptr + PTR_W'(1);
         end
         if (do_pop) begin
            rptr <= rptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   // Credits upstream guarantee a free slot for every arriving result
   overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
                                !(push && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fpu_fma_wb_queue.sv
// Tracks ops through the fixed-latency FMA pipe, captures their results into a
// writeback FIFO, and withholds issue credit so no result can be dropped.
module fpu_fma_wb_queue
   import fpu_fma_wb_queue_pkg::*;
#(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned DATA_W  = FP_REC_W_D,
   parameter int unsigned TAG_W   = FP_TAG_W,
   parameter int unsigned EXC_W   = FP_EXC_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [TAG_W-1:0]  issue_rd,
   input  logic              issue_single,
   input  logic              kill,
   input  logic [DATA_W-1:0] fma_data,
   input  logic [EXC_W-1:0]  fma_exc,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [TAG_W-1:0]  wb_rd,
   output logic              wb_single,
   output logic [DATA_W-1:0] wb_data,
   output logic [EXC_W-1:0]  wb_exc
);

   localparam int unsigned CRD_W = $clog2(DEPTH + 1);

   logic [LATENCY-1:0] trk_v;
   logic [LATENCY-1:0] trk_single;
   logic [TAG_W-1:0]   trk_rd [LATENCY];
   logic [CRD_W-1:0]   credit;
   logic [CRD_W-1:0]   fifo_count;
   logic               accept;
   logic               killed;
   logic               push;
   logic               pop;
   fpu_wb_entry_t      push_entry;
   fpu_wb_entry_t      head;

   assign issue_ready = credit < CRD_W'(DEPTH);
   assign accept      = issue_valid && issue_ready;
   assign killed      = kill && trk_v[0];
   assign push        = trk_v[LATENCY-1];
   assign wb_valid    = fifo_count != '0;
   assign pop         = wb_valid && wb_ready;

   // Result capture: the final tracker stage lines up with the pipe output
   always_comb begin
      push_entry        = '0;
      push_entry.rd     = FP_TAG_W'(trk_rd[LATENCY-1]);
      push_entry.single = trk_single[LATENCY-1];
      push_entry.data   = FP_REC_W_D'(fma_data);
      push_entry.exc    = FP_EXC_W'(fma_exc);
   end

   // Tag tracker shifts every cycle; credit covers in-flight tags plus buffered results
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         trk_v      <= '0;
         trk_single <= '0;
         trk_rd     <= '{default: '0};
         credit     <= '0;
      end else begin
         trk_v[0]      <= accept;
         trk_single[0] <= issue_single;
         trk_rd[0]     <= issue_rd;
         trk_v[1]      <= trk_v[0] && !kill;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            trk_single[i] <= trk_single[i-1];
            trk_rd[i]     <= trk_rd[i-1];
         end
         for (int unsigned i = 2; i < LATENCY; i++) begin
            trk_v[i] <= trk_v[i-1];
         end
         credit <= credit + CRD_W'(accept) - CRD_W'(pop) - CRD_W'(killed);
      end
   end

   fpu_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clock),
      .rst_n      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (fifo_count)
   );

   assign wb_rd     = TAG_W'(head.rd);
   assign wb_single = head.single;
   assign wb_data   = DATA_W'(head.data);
   assign wb_exc    = EXC_W'(head.exc);

endmodule

// File: tb/tb_fpu_fma_wb_queue.sv
// Bench for fpu_fma_wb_queue: directed vector table, corner-case sequences and
// random traffic checked against a queue-based model of in-flight ops and results.
module tb_fpu_fma_wb_queue;
   import fpu_fma_wb_queue_pkg::*;

   localparam int LATENCY = 4;
   localparam int DEPTH   = 4;
   localparam logic [64:0] ONE_D = 65'h0_3FF0000000000000;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic        issue_ready;
   logic [4:0]  issue_rd;
   logic        issue_single;
   logic        kill;
   logic [64:0] fma_data;
   logic [4:0]  fma_exc;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic        wb_single;
   logic [64:0] wb_data;
   logic [4:0]  wb_exc;

   always #5 clock = ~clock;

   fpu_fma_wb_queue #(
      .LATENCY (LATENCY),
      .DEPTH   (DEPTH),
      .DATA_W  (65),
      .TAG_W   (5),
      .EXC_W   (5)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_rd     (issue_rd),
      .issue_single (issue_single),
      .kill         (kill),
      .fma_data     (fma_data),
      .fma_exc      (fma_exc),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_single    (wb_single),
      .wb_data      (wb_data),
      .wb_exc       (wb_exc)
   );

   typedef struct {
      bit          iv;
      logic [4:0]  rd;
      bit          single;
      bit          kill;
      logic [64:0] data;
      logic [4:0]  exc;
      bit          wbr;
   } in_t;

   typedef struct {
      int         issued;
      logic [4:0] rd;
      bit         single;
   } op_t;

   typedef struct {
      logic [4:0]  rd;
      bit          single;
      logic [64:0] data;
      logic [4:0]  exc;
   } res_t;

   typedef struct {
      in_t         in;
      bit          ev;
      logic [4:0]  erd;
      bit          esingle;
      logic [64:0] edata;
      logic [4:0]  eexc;
      bit          eir;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int drops = 0;
   op_t        fly[$];
   res_t       mq[$];
   logic [4:0] got_q[$];
   vec_t       tbl[11];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic in_t mk_in(input bit iv, input logic [4:0] rd, input bit single,
                                 input bit kl, input logic [64:0] data,
                                 input logic [4:0] exc, input bit wbr);
      in_t r;
      r.iv = iv; r.rd = rd; r.single = single; r.kill = kl;
      r.data = data; r.exc = exc; r.wbr = wbr;
      return r;
   endfunction

   function automatic vec_t mk_vec(input in_t in, input bit ev, input logic [4:0] erd,
                                   input bit esingle, input logic [64:0] edata,
                                   input logic [4:0] eexc, input bit eir);
      vec_t v;
      v.in = in; v.ev = ev; v.erd = erd; v.esingle = esingle;
      v.edata = edata; v.eexc = eexc; v.eir = eir;
      return v;
   endfunction

   function automatic logic [64:0] rnd65();
      return {1'($urandom), 32'($urandom), 32'($urandom)};
   endfunction

   function automatic in_t idle(input bit wbr);
      return mk_in(1'b0, 5'd0, 1'b0, 1'b0, rnd65(), 5'($urandom), wbr);
   endfunction

   task automatic drive(input in_t in);
      issue_valid  = in.iv;
      issue_rd     = in.rd;
      issue_single = in.single;
      kill         = in.kill;
      fma_data     = in.data;
      fma_exc      = in.exc;
      wb_ready     = in.wbr;
   endtask

   task automatic check_model();
      bit ev;
      int crd;
      ev  = mq.size() != 0;
      crd = fly.size() + mq.size();
      chk("wb_valid", 128'(wb_valid), 128'(ev));
      chk("issue_ready", 128'(issue_ready), 128'(crd < DEPTH));
      if (ev) begin
         chk("wb_rd", 128'(wb_rd), 128'(mq[0].rd));
         chk("wb_single", 128'(wb_single), 128'(mq[0].single));
         chk("wb_data", 128'(wb_data), 128'(mq[0].data));
         chk("wb_exc", 128'(wb_exc), 128'(mq[0].exc));
      end
   endtask

   // Reference: an op issued at cycle t meets the pipe output at t+LATENCY
   task automatic model_edge(input in_t in);
      int crd;
      bit acc;
      res_t r;
      op_t  o;
      crd = fly.size() + mq.size();
      acc = in.iv && (crd < DEPTH);
      if (in.wbr && mq.size() != 0) void'(mq.pop_front());
      if (fly.size() != 0 && fly[0].issued + LATENCY == cyc) begin
         r.rd = fly[0].rd; r.single = fly[0].single; r.data = in.data; r.exc = in.exc;
         mq.push_back(r);
         void'(fly.pop_front());
      end
      if (in.kill && fly.size() != 0 && fly[fly.size()-1].issued == cyc - 1)
         void'(fly.pop_back());
      if (acc) begin
         o.issued = cyc; o.rd = in.rd; o.single = in.single;
         fly.push_back(o);
      end
      cyc++;
   endtask

   task automatic cycle(input in_t in);
      check_model();
      if (wb_valid && in.wbr) got_q.push_back(wb_rd);
      if (in.iv && !issue_ready) drops++;
      drive(in);
      @(posedge clock);
      model_edge(in);
      #1;
   endtask

   task automatic do_reset();
      drive(idle(1'b1));
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      fly.delete();
      mq.delete();
      got_q.delete();
      cyc = 0;
   endtask

   task automatic probe_credit(input string name, input int exp_acc);
      int acc;
      acc = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (issue_ready) acc++;
         cycle(mk_in(1'b1, 5'(20 + i), 1'b0, 1'b0, rnd65(), 5'd0, 1'b0));
      end
      chk(name, 128'(acc), 128'(exp_acc));
   endtask

   initial begin
      int k;
      reset = 1'b0;
      drive(idle(1'b1));
      do_reset();

      chk("rst_wb_valid", 128'(wb_valid), 128'(0));
      chk("rst_wb_rd", 128'(wb_rd), 128'(0));
      chk("rst_wb_single", 128'(wb_single), 128'(0));
      chk("rst_wb_data", 128'(wb_data), 128'(0));
      chk("rst_wb_exc", 128'(wb_exc), 128'(0));
      chk("rst_issue_ready", 128'(issue_ready), 128'(1));

      // Single op, then four issues from zero credit
      tbl[0] = mk_vec(mk_in(1'b1, 5'd7, 1'b0, 1'b0, '0, '0, 1'b1), 1'b0, '0, 1'b0, '0, '0, 1'b1);
      for (int i = 1; i < 4; i++)
         tbl[i] = mk_vec(mk_in(1'b0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b1), 1'b0, '0, 1'b0, '0, '0, 1'b1);
      tbl[4] = mk_vec(mk_in(1'b0, 5'd0, 1'b0, 1'b0, ONE_D, 5'h01, 1'b1), 1'b0, '0, 1'b0, '0, '0, 1'b1);
      tbl[5] = mk_vec(mk_in(1'b0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b1), 1'b1, 5'd7, 1'b0, ONE_D, 5'h01, 1'b1);
      for (int i = 6; i < 10; i++)
         tbl[i] = mk_vec(mk_in(1'b1, 5'(i + 2), 1'b0, 1'b0, '0, '0, 1'b0), 1'b0, '0, 1'b0, '0, '0, 1'b1);
      tbl[10] = mk_vec(mk_in(1'b0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0), 1'b0, '0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("tbl%0d_wb_valid", i), 128'(wb_valid), 128'(tbl[i].ev));
         chk($sformatf("tbl%0d_issue_ready", i), 128'(issue_ready), 128'(tbl[i].eir));
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d_wb_rd", i), 128'(wb_rd), 128'(tbl[i].erd));
            chk($sformatf("tbl%0d_wb_single", i), 128'(wb_single), 128'(tbl[i].esingle));
            chk($sformatf("tbl%0d_wb_data", i), 128'(wb_data), 128'(tbl[i].edata));
            chk($sformatf("tbl%0d_wb_exc", i), 128'(wb_exc), 128'(tbl[i].eexc));
         end
         cycle(tbl[i].in);
      end

      // Backpressure: six issues against a blocked write port
      do_reset();
      drops = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) chk("bp_ready_low", 128'(issue_ready), 128'(0));
         cycle(mk_in(1'b1, 5'(i + 1), i[0], 1'b0, rnd65(), 5'($urandom), 1'b0));
      end
      for (int i = 6; i < 9; i++) cycle(idle(1'b0));
      chk("bp_ready_pop_cycle", 128'(issue_ready), 128'(0));
      cycle(idle(1'b1));
      chk("bp_ready_after_pop", 128'(issue_ready), 128'(1));
      for (int i = 0; i < 6; i++) cycle(idle(1'b1));
      chk("bp_dropped", 128'(drops), 128'(2));
      chk("bp_drain_count", 128'(got_q.size()), 128'(4));
      for (int i = 0; i < got_q.size() && i < 4; i++)
         chk($sformatf("bp_drain_rd%0d", i), 128'(got_q[i]), 128'(i + 1));

      // Issue and pop on the same edge at credit 3
      do_reset();
      for (int i = 0; i < 3; i++)
         cycle(mk_in(1'b1, 5'(i + 1), 1'b0, 1'b0, rnd65(), 5'd0, 1'b0));
      for (int i = 3; i < 7; i++) cycle(idle(1'b0));
      cycle(mk_in(1'b1, 5'd4, 1'b0, 1'b0, rnd65(), 5'd0, 1'b1));
      chk("c3_ready_kept", 128'(issue_ready), 128'(1));
      cycle(mk_in(1'b1, 5'd5, 1'b0, 1'b0, rnd65(), 5'd0, 1'b0));
      chk("c3_ready_full", 128'(issue_ready), 128'(0));
      for (int i = 0; i < 12; i++) cycle(idle(1'b1));

      // Kill squashes the op issued one cycle earlier
      do_reset();
      cycle(mk_in(1'b1, 5'd2, 1'b1, 1'b0, rnd65(), 5'd0, 1'b1));
      cycle(mk_in(1'b1, 5'd3, 1'b0, 1'b0, rnd65(), 5'd0, 1'b1));
      cycle(mk_in(1'b0, 5'd0, 1'b0, 1'b1, rnd65(), 5'd0, 1'b1));
      cycle(idle(1'b1));
      cycle(mk_in(1'b0, 5'd0, 1'b0, 1'b0, 65'h0AAAA, 5'h10, 1'b1));
      cycle(mk_in(1'b0, 5'd0, 1'b0, 1'b0, 65'h0BBBB, 5'h08, 1'b1));
      for (int i = 0; i < 5; i++) cycle(idle(1'b1));
      chk("kill_wb_count", 128'(got_q.size()), 128'(1));
      if (got_q.size() > 0) chk("kill_wb_rd", 128'(got_q[0]), 128'(2));
      probe_credit("kill_credit_free", DEPTH);

      // Ten ops through a toggling write port to wrap the pointers
      do_reset();
      k = 0;
      for (int c = 0; c < 100 && got_q.size() < 10; c++) begin
         bit iv;
         iv = (k < 10) && ((fly.size() + mq.size()) < DEPTH);
         cycle(mk_in(iv, 5'(11 + k), 1'(k), 1'b0, rnd65(), 5'($urandom), (c % 2) == 0));
         if (iv) k++;
      end
      chk("wrap_count", 128'(got_q.size()), 128'(10));
      for (int i = 0; i < got_q.size() && i < 10; i++)
         chk($sformatf("wrap_rd%0d", i), 128'(got_q[i]), 128'(11 + i));

      // Reset with two results buffered and two still in the pipe
      do_reset();
      cycle(mk_in(1'b1, 5'd1, 1'b0, 1'b0, rnd65(), 5'd0, 1'b0));
      cycle(mk_in(1'b1, 5'd2, 1'b0, 1'b0, rnd65(), 5'd0, 1'b0));
      cycle(idle(1'b0));
      cycle(idle(1'b0));
      cycle(mk_in(1'b1, 5'd3, 1'b0, 1'b0, rnd65(), 5'd0, 1'b0));
      cycle(mk_in(1'b1, 5'd4, 1'b0, 1'b0, rnd65(), 5'd0, 1'b0));
      chk("mf_pre_valid", 128'(wb_valid), 128'(1));
      #1 reset = 1'b0;
      #1;
      chk("mf_async_valid", 128'(wb_valid), 128'(0));
      chk("mf_async_rd", 128'(wb_rd), 128'(0));
      chk("mf_async_ready", 128'(issue_ready), 128'(1));
      fly.delete();
      mq.delete();
      @(posedge clock);
      #1 reset = 1'b1;
      cyc = 0;
      for (int i = 0; i < LATENCY + 2; i++) begin
         chk("mf_no_stale", 128'(wb_valid), 128'(0));
         cycle(idle(1'b1));
      end

      // Random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle(mk_in($urandom_range(0, 99) < 60, 5'($urandom), 1'($urandom),
                     $urandom_range(0, 99) < 10, rnd65(), 5'($urandom),
                     $urandom_range(0, 99) < 50));
      end
      for (int i = 0; i < 12; i++) cycle(idle(1'b1));

      $display("upstream issue-while-not-ready events: %0d", drops);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
